tdm_demux_4: RTL
================

// Module: tdm_demux_4
// PURPOSE
//  Receive end of a 4-slot time-division link fed by the 4:1 mux path.
//  Takes one word per accepted beat on a shared bus and routes it to one of
//  four registered channel outputs, selected by a frame-aligned slot counter.
//  A HUNT/LOCKED FSM aligns slots to frame_sync and flags misalignment.
// PARAMETERS
//  W  8  data word width in bits (W >= 1)
// PORTS
//  clk          in   1    single clock, all logic on posedge
//  rst          in   1    synchronous, active-high reset
//  din          in   W    shared TDM data word
//  din_valid    in   1    din is valid this cycle (one beat = one slot)
//  frame_sync   in   1    qualified by din_valid: this beat is slot 0
//  ch0..ch3     out  W    per-channel hold registers
//  ch_valid     out  4    one-cycle pulse, bit n = chn updated this cycle
//  frame_done   out  1    one-cycle pulse, slot 3 written
//  sync_err     out  1    one-cycle pulse, frame_sync at slot != 0 while LOCKED
//  locked       out  1    FSM is in LOCKED
// BEHAVIOUR
//  - Reset (rst=1 at posedge): ch0..ch3=0, ch_valid=0, frame_done=0,
//    sync_err=0, locked=0, slot=0, FSM=HUNT. Reset wins over all inputs,
//    including mid-frame; a partial frame is discarded.
//  - Latency: 1 cycle. Beat accepted at edge k -> chN/ch_valid[N] at edge k.
//    No backpressure; every din_valid beat is consumed.
//  - frame_sync without din_valid is ignored.
//  - HUNT: beats with frame_sync=0 dropped (no outputs). Beat with
//    frame_sync=1 -> write ch0, pulse ch_valid[0], slot<=1, FSM<=LOCKED.
//  - LOCKED: frame_sync=0 -> write ch[slot], pulse ch_valid[slot],
//    slot<=slot+1 (2-bit, wraps 3->0). Slot 3 write also pulses frame_done.
//  - LOCKED, frame_sync=1, slot==0: normal slot-0 write, no error.
//  - LOCKED, frame_sync=1, slot!=0: sync_err pulse, word written to ch0,
//    ch_valid[0] pulse, slot<=1; stays LOCKED; no frame_done.
//  - Non-addressed channel registers hold value; ch_valid is one-hot or zero.
//  - din_valid=0: slot, FSM, ch regs hold; all pulse outputs 0.
//  - locked is 1 one cycle after the aligning beat, until rst.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined:
//   - adds input din_par (1) = even parity over din; output par_err (1).
//   - beat with ^{din,din_par}=1: par_err pulse, channel NOT written, no
//     ch_valid pulse, no frame_done; slot/FSM advance exactly as for a
//     good beat (HUNT+frame_sync still locks). par_err resets to 0.
//  Not defined: din_par/par_err ports absent; every beat is written.
// TESTING
//  1. rst 2 cycles -> all outputs 0, locked=0; beats w/o frame_sync in HUNT
//     -> no ch_valid.
//  2. Beats 0x11(sync),0x22,0x33,0x44 -> ch0..ch3=11,22,33,44;
//     ch_valid 1,2,4,8 on successive cycles; frame_done with 0x44; locked=1.
//  3. Two frames back to back, idle gaps (din_valid=0) inside frame 2 ->
//     slot holds over gaps; frame 2 fills ch0..ch3 in order, no sync_err.
//  4. LOCKED, frame_sync on 3rd beat (0xAA) -> sync_err=1, ch0=0xAA,
//     ch_valid=1, next beat lands in ch1.
//  5. rst asserted after 2 beats of a frame -> outputs 0, HUNT; next beat
//     w/o frame_sync dropped.
//  6. TDM_DEMUX_PARITY_EN: slot-2 beat 0x55 with din_par=1 -> par_err=1,
//     ch2 unchanged, ch_valid=0; next beat writes ch3 with frame_done.

Source files
------------

// File: rtl/tdm_demux_4.sv
// 4-slot TDM receive demux: routes each accepted beat to a frame-aligned channel register.
// Optional even-parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
//
// state  | meaning
// HUNT   | waiting for a frame_sync beat; non-sync beats are dropped
// LOCKED | slot counter aligned; beats routed to ch[slot]
module tdm_demux_4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic         din_par,
  output logic         par_err,
`endif
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic [3:0]   ch_valid,
  output logic         frame_done,
  output logic         sync_err,
  output logic         locked
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t       r_state;
  logic [1:0]   r_slot;
  logic [W-1:0] r_ch [4];
  logic [3:0]   r_ch_valid;
  logic         r_frame_done;
  logic         r_sync_err;
  logic         r_locked;

  logic         w_wr;
  logic [1:0]   w_tgt;
  logic [1:0]   w_next_slot;
  state_t       w_next_state;
  logic         w_sync_err;
  logic         w_frame_done;
  logic         w_good;

`ifdef TDM_DEMUX_PARITY_EN
  logic r_par_err;
  // A bad-parity beat still advances slot/FSM, but no channel is written.
  assign w_good  = ~(^{din, din_par});
  assign par_err = r_par_err;
`else
  assign w_good = 1'b1;
`endif

  always_comb begin
    w_wr         = 1'b0;
    w_tgt        = 2'd0;
    w_next_slot  = r_slot;
    w_next_state = r_state;
    w_sync_err   = 1'b0;
    w_frame_done = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_wr         = 1'b1;
            w_tgt        = 2'd0;
            w_next_slot  = 2'd1;
            w_next_state = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            w_wr        = 1'b1;
            w_tgt       = 2'd0;
            w_next_slot = 2'd1;
            w_sync_err  = (r_slot != 2'd0);
          end else begin
            w_wr         = 1'b1;
            w_tgt        = r_slot;
            w_next_slot  = r_slot + 2'd1;
            w_frame_done = (r_slot == 2'd3);
          end
        end
        default: w_next_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_slot       <= 2'd0;
      r_ch_valid   <= 4'd0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
      for (int i = 0; i < 4; i++) r_ch[i] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_slot       <= w_next_slot;
      r_locked     <= (w_next_state == LOCKED);
      r_sync_err   <= w_sync_err;
      r_frame_done <= w_frame_done & w_good;
      if (w_wr && w_good) begin
        r_ch[w_tgt] <= din;
        r_ch_valid  <= 4'b0001 << w_tgt;
      end else begin
        r_ch_valid  <= 4'd0;
      end
`ifdef TDM_DEMUX_PARITY_EN
      r_par_err    <= din_valid & ~w_good;
`endif
    end
  end

  assign ch0        = r_ch[0];
  assign ch1        = r_ch[1];
  assign ch2        = r_ch[2];
  assign ch3        = r_ch[3];
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule
